// File: rtl/kb_digit_ctrl_if.sv
// ---------------------------------------------------------------------------
// kb_digit_ctrl_if
// Bundles the scan-code input strobe and the seven-segment display outputs
// of the keyboard digit controller.
//   sc_valid : 1-cycle strobe, sc holds a complete received byte
//   sc       : PS/2 set-2 scan-code byte
//   num      : segment pattern {dp,g,f,e,d,c,b,a}, active-low
//   seg_en   : digit enables, active-low, one-hot-zero
//   dig_cnt  : number of valid digits in the buffer (0..4)
// Modports:
//   master : scan-code source / display consumer
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface kb_digit_ctrl_if;
    logic       sc_valid;
    logic [7:0] sc;
    logic [7:0] num;
    logic [3:0] seg_en;
    logic [2:0] dig_cnt;

    modport master (
        output sc_valid, sc,
        input  num, seg_en, dig_cnt
    );

    modport slave (
        input  sc_valid, sc,
        output num, seg_en, dig_cnt
    );
endinterface

// File: rtl/kb_digit_ctrl.sv
// ---------------------------------------------------------------------------
// kb_digit_ctrl
// Decodes PS/2 make/break/extended sequences, suppresses typematic repeats,
// keeps a 4-digit shift buffer of typed decimal digits and time-multiplexes
// that buffer onto a shared seven-segment bus.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : kb_digit_ctrl_if.slave (sc_valid, sc in; num, seg_en, dig_cnt out)
// Parameters:
//   REFRESH_CYCLES : clk cycles each digit stays enabled (>= 2)
// ---------------------------------------------------------------------------
module kb_digit_ctrl #(
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            rst,
    kb_digit_ctrl_if.slave  bus
);

    localparam int              RC_W    = $clog2(REFRESH_CYCLES);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_CYCLES - 1);

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } state_t;

    // Returns {is_digit, bcd} for a set-2 make code.
    function automatic logic [4:0] digit_of(input logic [7:0] code);
        case (code)
            8'h45:   digit_of = {1'b1, 4'd0};
            8'h16:   digit_of = {1'b1, 4'd1};
            8'h1E:   digit_of = {1'b1, 4'd2};
            8'h26:   digit_of = {1'b1, 4'd3};
            8'h25:   digit_of = {1'b1, 4'd4};
            8'h2E:   digit_of = {1'b1, 4'd5};
            8'h36:   digit_of = {1'b1, 4'd6};
            8'h3D:   digit_of = {1'b1, 4'd7};
            8'h3E:   digit_of = {1'b1, 4'd8};
            8'h46:   digit_of = {1'b1, 4'd9};
            default: digit_of = 5'd0;
        endcase
    endfunction

    // Active-low segment pattern; blank entries are fully dark.
    function automatic logic [7:0] seg_of(input logic valid, input logic [3:0] bcd);
        if (!valid) begin
            seg_of = 8'hFF;
        end else begin
            case (bcd)
                4'd0:    seg_of = 8'hC0;
                4'd1:    seg_of = 8'hF9;
                4'd2:    seg_of = 8'hA4;
                4'd3:    seg_of = 8'hB0;
                4'd4:    seg_of = 8'h99;
                4'd5:    seg_of = 8'h92;
                4'd6:    seg_of = 8'h82;
                4'd7:    seg_of = 8'hF8;
                4'd8:    seg_of = 8'h80;
                4'd9:    seg_of = 8'h90;
                default: seg_of = 8'hFF;
            endcase
        end
    endfunction

    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_held_code;
    logic            r_held_v;
    logic [3:0]      r_dv;          // per-digit valid, bit 0 = d0
    logic [3:0][3:0] r_bcd;         // per-digit BCD, [0] = d0
    logic [2:0]      r_dig_cnt;
    logic [RC_W-1:0] r_rc;
    logic [1:0]      r_idx;
    logic [7:0]      r_num;
    logic [3:0]      r_seg_en;

    logic            w_make;
    logic            w_break;
    logic            w_repeat;
    logic            w_accept;
    logic [4:0]      w_digit;
    logic            w_wrap;
    logic [1:0]      w_idx_next;

    // ---------------------------------------------------------------------
    // Decoder FSM
    // ---------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_make       = 1'b0;
        w_break      = 1'b0;
        if (bus.sc_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.sc == SC_BREAK)    w_state_next = ST_BRK;
                    else if (bus.sc == SC_EXT) w_state_next = ST_EXT;
                    else                       w_make       = 1'b1;
                end
                ST_BRK: begin
                    w_break      = 1'b1;
                    w_state_next = ST_IDLE;
                end
                ST_EXT: begin
                    // Extended makes are swallowed; only the F0 prefix matters.
                    w_state_next = (bus.sc == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: w_state_next = ST_IDLE;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    // A make matching the still-held key is auto-repeat and is dropped whole.
    assign w_repeat = r_held_v && (bus.sc == r_held_code);
    assign w_accept = w_make && !w_repeat;
    assign w_digit  = digit_of(bus.sc);

    // ---------------------------------------------------------------------
    // Held key and digit buffer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held_code <= 8'h00;
            r_held_v    <= 1'b0;
        end else if (w_accept) begin
            r_held_code <= bus.sc;
            r_held_v    <= 1'b1;
        end else if (w_break && (bus.sc == r_held_code)) begin
            r_held_v    <= 1'b0;
        end
    end

    // NOTE: the four-entry buffer is ordinary flops, not a RAM, and must come
    // out of reset blank, so it is reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dv      <= 4'b0000;
            r_bcd     <= '0;
            r_dig_cnt <= 3'd0;
        end else if (w_accept) begin
            if (w_digit[4]) begin
                // Shift up: d3 falls off, new digit enters at d0.
                r_dv  <= {r_dv[2:0], 1'b1};
                r_bcd <= {r_bcd[2:0], w_digit[3:0]};
                if (r_dig_cnt != 3'd4) r_dig_cnt <= r_dig_cnt + 3'd1;
            end else if (bus.sc == SC_BKSP) begin
                if (r_dig_cnt != 3'd0) begin
                    r_dv      <= {1'b0, r_dv[3:1]};
                    r_bcd     <= {4'h0, r_bcd[3:1]};
                    r_dig_cnt <= r_dig_cnt - 3'd1;
                end
            end else if (bus.sc == SC_ESC) begin
                r_dv      <= 4'b0000;
                r_bcd     <= '0;
                r_dig_cnt <= 3'd0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Display scan
    // ---------------------------------------------------------------------
    assign w_wrap     = (r_rc == RC_LAST);
    assign w_idx_next = w_wrap ? r_idx + 2'd1 : r_idx;

    // Enable and pattern are both computed from the next index so they change
    // on the same edge; the pattern uses the buffer as it stands before this
    // edge, giving one extra cycle of latency after a buffer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rc     <= '0;
            r_idx    <= 2'd0;
            r_seg_en <= 4'b1110;
            r_num    <= 8'hFF;
        end else begin
            r_rc     <= w_wrap ? '0 : r_rc + 1'b1;
            r_idx    <= w_idx_next;
            r_seg_en <= ~(4'b0001 << w_idx_next);
            r_num    <= seg_of(r_dv[w_idx_next], r_bcd[w_idx_next]);
        end
    end

    assign bus.num     = r_num;
    assign bus.seg_en  = r_seg_en;
    assign bus.dig_cnt = r_dig_cnt;

endmodule

// File: tb/tb_kb_digit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_kb_digit_ctrl
// Directed scan-code sequences for kb_digit_ctrl. Each sequence pushes the
// expected display frame (four digit patterns plus dig_cnt) onto a
// scoreboard; an independent monitor checks every displayed digit slot
// against the front frame and checks scan order and slot length throughout.
// ---------------------------------------------------------------------------
module tb_kb_digit_ctrl;

    localparam int RC = 4;

    typedef struct packed {
        logic [3:0][7:0] num;   // [0] = digit 0
        logic [2:0]      cnt;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kb_digit_ctrl_if bus ();

    kb_digit_ctrl #(.REFRESH_CYCLES(RC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    frame_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sends n bytes back-to-back, one strobe per cycle; v holds them with the
    // first byte in the most significant used position.
    task automatic send(input int n, input logic [8*16-1:0] v);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sc_valid = 1'b1;
            bus.sc       = v[8*(n-1-i) +: 8];
        end
        @(negedge clk);
        bus.sc_valid = 1'b0;
        bus.sc       = 8'h00;
    endtask

    // Pushes an expected frame once the buffer has settled, then waits
    // (bounded) for the monitor to consume it.
    task automatic expect_frame(input logic [7:0] d3, input logic [7:0] d2,
                                input logic [7:0] d1, input logic [7:0] d0,
                                input logic [2:0] cnt);
        frame_t f;
        f.num = {d3, d2, d1, d0};
        f.cnt = cnt;
        @(posedge clk);
        #1;
        sb.push_back(f);
        for (int i = 0; i < 20 * RC && sb.size() != 0; i++) @(negedge clk);
        check("sb_drain", sb.size(), 0);
    endtask

    // ---------------------------------------------------------------------
    // Monitor: slot boundaries are seen as seg_en changes.
    // ---------------------------------------------------------------------
    initial begin
        logic [3:0] prev_en;
        int         len;
        bit         first;
        int         slots;
        int         idx;
        frame_t     f;
        prev_en = 4'b1110;
        len     = 0;
        first   = 1'b1;
        slots   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en = 4'b1110;
                len     = 0;
                first   = 1'b1;
            end else if (bus.seg_en != prev_en) begin
                if (!first) check("slot_len", len, RC);
                first = 1'b0;
                check("scan_order", bus.seg_en, {prev_en[2:0], prev_en[3]});
                case (bus.seg_en)
                    4'b1110: idx = 0;
                    4'b1101: idx = 1;
                    4'b1011: idx = 2;
                    4'b0111: idx = 3;
                    default: idx = 0;
                endcase
                if (sb.size() != 0) begin
                    f = sb[0];
                    check($sformatf("num_d%0d", idx), bus.num, f.num[idx]);
                    check("dig_cnt", bus.dig_cnt, f.cnt);
                    slots++;
                    if (slots == 4) begin
                        void'(sb.pop_front());
                        slots = 0;
                    end
                end
                prev_en = bus.seg_en;
                len     = 1;
            end else begin
                len++;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        rst          = 1'b1;
        bus.sc_valid = 1'b0;
        bus.sc       = 8'h00;
        #1;
        check("rst_seg_en", bus.seg_en, 4'b1110);
        check("rst_num", bus.num, 8'hFF);
        check("rst_dig_cnt", bus.dig_cnt, 3'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Digit entry 1,2,3 with breaks.
        send(9, {8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26});
        expect_frame(8'hFF, 8'hF9, 8'hA4, 8'hB0, 3'd3);

        // Esc, then typematic: repeats dropped, make after break accepted.
        send(3, {8'h76, 8'hF0, 8'h76});
        expect_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd0);
        send(6, {8'h25, 8'h25, 8'h25, 8'hF0, 8'h25, 8'h25});
        expect_frame(8'hFF, 8'hFF, 8'h99, 8'h99, 3'd2);
        send(2, {8'hF0, 8'h25});

        // Overflow: 1..5 leaves 2,3,4,5.
        send(3, {8'h76, 8'hF0, 8'h76});
        send(15, {8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26,
                  8'h25, 8'hF0, 8'h25, 8'h2E, 8'hF0, 8'h2E});
        expect_frame(8'hA4, 8'hB0, 8'h99, 8'h92, 3'd4);

        // Backspace, Esc, Backspace at empty.
        send(3, {8'h66, 8'hF0, 8'h66});
        expect_frame(8'hFF, 8'hA4, 8'hB0, 8'h99, 3'd3);
        send(3, {8'h76, 8'hF0, 8'h76});
        expect_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd0);
        send(3, {8'h66, 8'hF0, 8'h66});
        expect_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd0);

        // Hold 0; extended sequences must not touch buffer or held key, so
        // the final 45 is still a repeat.
        send(1, {8'h45});
        send(6, {8'hE0, 8'h45, 8'hE0, 8'hF0, 8'h45, 8'h45});
        expect_frame(8'hFF, 8'hFF, 8'hFF, 8'hC0, 3'd1);

        // Lone F0, reset mid-frame, then 45 must be a make.
        send(1, {8'hF0});
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_seg_en", bus.seg_en, 4'b1110);
        check("mid_rst_num", bus.num, 8'hFF);
        check("mid_rst_dig_cnt", bus.dig_cnt, 3'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(1, {8'h45});
        expect_frame(8'hFF, 8'hFF, 8'hFF, 8'hC0, 3'd1);

        // Unknown key held, then a digit without its break.
        send(2, {8'h1C, 8'h16});
        expect_frame(8'hFF, 8'hFF, 8'hC0, 8'hF9, 3'd2);
        // 1C is no longer held, so it re-takes the held slot and 16 is new.
        send(2, {8'h1C, 8'h16});
        expect_frame(8'hFF, 8'hC0, 8'hF9, 8'hF9, 3'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kb_digit_ctrl.md
# kb_digit_ctrl

Sequencing controller between the PS/2 scan-code receiver and the 4-digit seven-segment display in the keyboard lab design. It consumes validated scan-code bytes and runs the make/break/extended-prefix state machine. It suppresses typematic repeats and maintains a 4-digit shift buffer of typed decimal digits. It also time-multiplexes that buffer onto the shared segment bus (`num`) and the digit enables (`seg_en`).

## Interface
- `REFRESH_CYCLES`, default 100000: clk cycles each digit stays enabled (≥2).
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sc_valid` in 1: one-cycle strobe; `sc` holds a complete received byte. May be asserted on consecutive cycles.
- `sc` in 8: scan-code byte (PS/2 set 2).
- `num` out 8: segment pattern {dp,g,f,e,d,c,b,a}, active-low, registered.
- `seg_en` out 4: digit enables, active-low, one-hot-zero, registered.
- `dig_cnt` out 3: number of valid digits in buffer, 0..4, registered.

## Operation
- Decoder FSM states: IDLE, BRK, EXT, EXT_BRK. It advances only on `sc_valid`.
  - IDLE: 0xF0 → BRK. 0xE0 → EXT. Any other byte is a make code; handle it, stay IDLE.
  - BRK: any byte is a break code; handle it, → IDLE.
  - EXT: 0xF0 → EXT_BRK. Any other byte is ignored, → IDLE.
  - EXT_BRK: any byte is ignored, → IDLE. Extended keys never touch the buffer or held key.
- Held key: `held_code[7:0]` plus `held_v`.
  - Make with `held_v` and `sc == held_code`: typematic repeat, ignored entirely.
  - Otherwise a make sets `held_code = sc` and `held_v = 1`, then executes its action.
  - Break with `sc == held_code` clears `held_v`. A break for any other code has no effect.
- Make actions:
  - Digits 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9: shift buffer up. d3 is lost, d2→d3, d1→d2, d0→d1, new digit→d0. `dig_cnt` saturates at 4.
  - 0x66 (Backspace): shift down. d1→d0, d2→d1, d3→d2, d3 blank, `dig_cnt` −1. No-op when 0.
  - 0x76 (Esc): blank all digits, `dig_cnt` = 0.
  - Any other make: updates the held key only; buffer unchanged.
- Buffer: four entries {valid, bcd[3:0]}. d0 shows on digit 0 (`seg_en[0]`).
- Scan: counter `rc` runs 0..REFRESH_CYCLES−1. On wrap, `idx` = (`idx`+1) mod 4, with 3 wrapping to 0.
- Display output:
  - `seg_en` = ~(1<<`idx`).
  - `num` = pattern of d[`idx`]: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
  - Invalid (blank) entry → FF.

## Timing
- Reset values (asynchronous, immediate):
  - FSM = IDLE, `held_v` = 0, buffer all blank, `dig_cnt` = 0.
  - `rc` = 0, `idx` = 0.
  - `seg_en` = 4'b1110, `num` = 8'hFF.
- Byte handling: the buffer and `dig_cnt` update on the edge that samples `sc_valid`. `num` reflects the new buffer one edge later (2-cycle strobe-to-segment latency when `idx` selects the affected digit).
- `seg_en` and `num` change on the same edge. There is never a cycle in which a new enable carries the previous digit's pattern.
- Each digit is enabled for exactly REFRESH_CYCLES cycles; full frame = 4×REFRESH_CYCLES.
- Back-to-back strobes are each processed. F0 then code on consecutive cycles is legal.
- Scan advance coincident with a buffer update: both take effect. `num` shows the new `idx` with the pre-update buffer for one cycle, then the updated value.
- Reset mid-sequence (e.g. after F0): FSM returns to IDLE. The next byte is treated as a make.
- Shift-up at `dig_cnt` = 4 discards d3. Backspace at 0 and Esc at 0 leave all state unchanged except the held key.

## Test plan
- Reset: assert `rst` mid-frame → `seg_en`=1110, `num`=FF, `dig_cnt`=0 immediately, independent of clk.
- Digit entry (REFRESH_CYCLES=4): bytes 16,F0,16,1E,F0,1E,26,F0,26 → `dig_cnt`=3. Scan shows d0=B0, d1=A4, d2=F9, d3=FF, with each `seg_en` low for exactly 4 cycles.
- Typematic: 25,25,25,F0,25, then 25 → two digits "4","4". The first held repeats are dropped; the make after the break is accepted.
- Overflow and edit: type 1,2,3,4,5 → buffer d3..d0 = 2,3,4,5. Backspace → d3..d0 = blank,2,3,4 with `dig_cnt`=3. Esc → all FF, `dig_cnt`=0.
- Extended/break prefixes: E0,45 then E0,F0,45 → buffer unchanged, `held_v` unchanged. Then reset after a lone F0, then 45 → digit 0 entered.
- Unknown key held: 1C (A), then 16 without a break → 1 entered; 1C no longer held.
